// File: rtl/ecc_pkg.sv
// Shared definitions for the scalar-multiplication control path: curve width,
// scan FSM encoding and window-count helpers.
package ecc_pkg;

    localparam int KW_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } scan_state_e;

    function automatic int num_windows(input int kw, input int win);
        return (kw + win - 1) / win;
    endfunction

    // Index width never collapses to zero, even for a single window.
    function automatic int idx_width(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage

// File: rtl/scalar_shreg.sv
// Load/shift register for the padded scalar; exposes its top WIN-bit window.
module scalar_shreg #(
    parameter int SW  = 256,
    parameter int WIN = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           shift,
    input  logic [SW-1:0]  din,
    output logic [WIN-1:0] top_win
);

    logic [SW-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rst_n)     sr <= '0;
        else if (load)  sr <= din;
        else if (shift) sr <= sr << WIN;
    end

    assign top_win = sr[SW-1 -: WIN];

endmodule

// File: rtl/scalar_window_scan.sv
// Streams a latched scalar MSB-first as WIN-bit digits over valid/ready,
// optionally skipping leading zero windows and flagging the zero scalar.
module scalar_window_scan
    import ecc_pkg::*;
#(
    parameter  int KW      = KW_DEFAULT,
    parameter  int WIN     = 1,
    parameter  int SKIP_LZ = 1,
    localparam int NW      = num_windows(KW, WIN),
    localparam int IW      = idx_width(NW)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [KW-1:0]  k,
    output logic           busy,
    output logic           dig_valid,
    input  logic           dig_ready,
    output logic [WIN-1:0] digit,
    output logic [IW-1:0]  idx,
    output logic           dig_first,
    output logic           dig_last,
    output logic           done,
    output logic           zero_k
);

    localparam int SW = NW * WIN;

    scan_state_e    state, state_nxt;
    logic [IW-1:0]  idx_r;
    logic           seen, zero_r;
    logic           load, shift, set_zero;
    logic [WIN-1:0] top_win;
    logic           top_zero, idx_zero, hs;

    scalar_shreg #(.SW(SW), .WIN(WIN)) u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .shift   (shift),
        .din     (SW'(k)),
        .top_win (top_win)
    );

    assign top_zero = (top_win == '0);
    assign idx_zero = (idx_r == '0);
    assign hs       = (state == EMIT) && dig_ready;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        set_zero  = 1'b0;
        case (state)
            IDLE: if (start) begin
                load      = 1'b1;
                state_nxt = SCAN;
            end
            SCAN: begin
                if (SKIP_LZ != 0 && top_zero) begin
                    // Reaching window 0 still zero means the whole scalar was zero.
                    if (!idx_zero) begin
                        shift = 1'b1;
                    end else begin
                        set_zero  = 1'b1;
                        state_nxt = DONE;
                    end
                end else begin
                    state_nxt = EMIT;
                end
            end
            EMIT: if (dig_ready) begin
                if (idx_zero) state_nxt = DONE;
                else          shift     = 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx_r  <= '0;
            seen   <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                idx_r  <= IW'(NW - 1);
                seen   <= 1'b0;
                zero_r <= 1'b0;
            end else if (shift) begin
                idx_r <= idx_r - 1'b1;
            end
            if (hs)       seen   <= 1'b1;
            if (set_zero) zero_r <= 1'b1;
        end
    end

    assign busy      = (state != IDLE);
    assign dig_valid = (state == EMIT);
    assign digit     = dig_valid ? top_win : '0;
    assign idx       = idx_r;
    assign dig_first = dig_valid && !seen;
    assign dig_last  = dig_valid && idx_zero;
    assign done      = (state == DONE);
    assign zero_k    = zero_r;

endmodule

// File: doc/scalar_window_scan.md
Name: scalar_window_scan

Overview:
- Scalar-digit sequencer for the Montgomery-ladder / windowed scalar-multiplication datapath.
- Latches a KW-bit scalar k and streams it MSB-first to the point-arithmetic controller as WIN-bit digits over a valid/ready handshake.
- Optionally skips leading zero windows, and flags the zero scalar.
- Generalises the single-bit k[t] index lookup: width, window size, skip mode, backpressure and completion signalling are all added.

Parameters:
- KW, 256, scalar width in bits.
- WIN, 1, digit/window width in bits (1..8).
- SKIP_LZ, 1, 1 = skip leading all-zero windows before the first emitted digit; 0 = emit every window.
- NW (localparam), (KW+WIN-1)/WIN, number of windows; scalar zero-padded at the top to NW*WIN bits.
- IW (localparam), $clog2(NW) (min 1), window-index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  load k and begin scan; honoured only in IDLE
- k  in  KW  scalar, sampled on the clk edge where start is accepted
- busy  out  1  high in every state except IDLE
- dig_valid  out  1  digit available
- dig_ready  in  1  consumer accepts digit
- digit  out  WIN  current window, MSB-aligned from the top of the padded scalar
- idx  out  IW  window index of digit (NW-1 .. 0)
- dig_first  out  1  current digit is the first emitted digit
- dig_last  out  1  current digit is window 0
- done  out  1  one-cycle pulse at scan completion
- zero_k  out  1  sticky: last scan found k==0; cleared on the next accepted start

Behaviour:
- Reset: state=IDLE, and every output is 0 (busy, dig_valid, digit, idx, dig_first, dig_last, done, zero_k). The shift register is cleared.
- rst_n low has priority over everything. Reset mid-scan aborts immediately: no done pulse, no further digits.
- FSM states: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - On start (edge E0), load sr <= zero-padded k, idx <= NW-1, seen <= 0, zero_k <= 0; go to SCAN.
  - start is ignored in every other state.
- SCAN (one top window examined per cycle):
  - If SKIP_LZ=1, the top window is 0 and idx != 0: shift sr left by WIN, decrement idx, stay in SCAN.
  - If SKIP_LZ=1, the top window is 0 and idx == 0: set zero_k=1 and go to DONE. No digit is ever emitted.
  - Otherwise go to EMIT.
- EMIT:
  - Output levels: dig_valid=1, digit=sr top window, dig_first=!seen, dig_last=(idx==0).
  - On dig_valid & dig_ready: set seen=1. If idx==0 go to DONE; otherwise shift sr, decrement idx and stay in EMIT. This gives one digit per cycle under continuous ready.
  - While dig_ready=0, digit, idx, dig_first and dig_last hold stable.
- DONE: done=1 for exactly one cycle, busy=1 during it, then IDLE. A start asserted in the DONE cycle is ignored.
- Timing, counting cycles after E0:
  - SCAN evaluates idx NW-1 in cycle 1.
  - First dig_valid appears in cycle 2+s, where s = number of skipped windows.
  - After the last handshake in cycle c, done is high in cycle c+1.
- SKIP_LZ=0: SCAN always takes exactly 1 cycle. k=0 then emits NW zero digits, and zero_k stays 0.
- Padding: with KW%WIN != 0, the top window contains (NW*WIN-KW) leading zero bits.
- Total handshakes per scan = idx_at_first_emit + 1.

Decomposition:
- Shared package (ecc_pkg): the KW default (curve width 256), the state encoding enum (IDLE/SCAN/EMIT/DONE), and the helper function for the NW/IW calculation.
- One natural sub-module: scalar_shreg (a load/shift-by-WIN register exposing its top window). The FSM, idx counter and flags stay in the top level.

Test Plan:
- KW=256, WIN=1, SKIP_LZ=1, k=5:
  - 253 skip cycles; digits 1,0,1 at idx 2,1,0.
  - dig_first on idx 2 only; dig_last on idx 0 only.
  - First dig_valid in cycle 255; done one cycle after the 3rd handshake.
- KW=256, WIN=4, SKIP_LZ=1, k=0xA5: digits 0xA (idx 1), 0x5 (idx 0), then done. Repeat with KW=10, WIN=4, k=10'h3FF: digits 0x3, 0xF, 0xF (top window padded).
- k=0:
  - SKIP_LZ=1 → no dig_valid, done pulse after 256 SCAN cycles, zero_k=1 until the next start.
  - SKIP_LZ=0 → 256 zero digits, zero_k=0.
- Backpressure, WIN=1, k=5: hold dig_ready=0 for 5 cycles on each digit → digit, idx and flags stable throughout; exactly 3 handshakes; no duplicated or dropped digit.
- start pulsed during SCAN, EMIT and DONE → ignored (digit sequence unchanged). A new start in IDLE after done reloads and clears zero_k.
- rst_n low for 1 cycle mid-EMIT → next cycle all outputs 0 and state IDLE; no done pulse; a following start with k=3 yields digits 1,1.
